// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
// Used by fb_arb_rr_pick and fb_port_arbiter.
package fb_arb_pkg;

   localparam int NUM_REQ       = 3;
   localparam int IMG_WIDTH     = 1280;
   localparam int IMG_HEIGHT    = 720;
   localparam int FB_ADDR_WIDTH = 20;
   localparam int FB_DATA_WIDTH = 24;
   localparam int FB_BURST_MAX  = 8;
   localparam int STAT_WIDTH    = 16;

   typedef enum logic [1:0] {
      REQ_RX_WR = 2'd0,
      REQ_SOBEL = 2'd1,
      REQ_DBG   = 2'd2
   } req_id_t;

   typedef struct packed {
      logic                     we;
      logic [FB_ADDR_WIDTH-1:0] addr;
      logic [FB_DATA_WIDTH-1:0] wdata;
   } fb_req_t;

   // (base + ofs) mod NUM_REQ, for base and ofs already below NUM_REQ.
   function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] ofs);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, ofs};
      if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
      return sum[1:0];
   endfunction

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fb_arb_rr_pick.sv
// Combinational rotate-priority picker: first valid requester found when
// scanning upward (with wrap) from the start index.
module fb_arb_rr_pick
   import fb_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic [1:0]         start,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         winner,
   output logic               any
);

   logic [1:0] idx;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = rr_idx(start, 2'(k));
         if (!any && valid[idx]) begin
            any         = 1'b1;
            winner      = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port frame buffer
// between three requesters. Optional statistics: define FB_ARB_STATS_EN.
module fb_port_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
   parameter int DATA_WIDTH = FB_DATA_WIDTH,
   parameter int BURST_MAX  = FB_BURST_MAX
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata
`ifdef FB_ARB_STATS_EN
   ,
   input  logic                          stat_clr,
   output logic [NUM_REQ*STAT_WIDTH-1:0] stat_grants,
   output logic [NUM_REQ*STAT_WIDTH-1:0] stat_max_wait
`endif
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   req_id_t                owner_q, owner_d;
   logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic                   rd_v1_q, rd_v1_d, rd_v2_q, rd_v2_d;
   logic [1:0]             tag1_q, tag1_d, tag2_q, tag2_d;

   logic [NUM_REQ-1:0]     pick_grant, grant;
   logic [1:0]             pick_winner, winner;
   logic                   pick_any, owner_ok;
   logic                   sel_we;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;

   fb_arb_rr_pick u_pick (
      .valid  (req_valid),
      .start  (rr_idx(owner_q, 2'd1)),
      .grant  (pick_grant),
      .winner (pick_winner),
      .any    (pick_any)
   );

   // The owner keeps the port until its burst is used up; the picker's scan
   // ends on the owner, so a lone owner is still granted past BURST_MAX.
   assign owner_ok = req_valid[owner_q] && (burst_cnt_q < CNT_W'(BURST_MAX));

   always_comb begin
      grant  = pick_grant;
      winner = pick_winner;
      if (owner_ok) begin
         grant          = '0;
         grant[owner_q] = 1'b1;
         winner         = owner_q;
      end
   end

   // No handshake may complete while reset is flushing the pipeline.
   assign req_ready = reset ? '0 : grant;

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant[r]) begin
            sel_we    = req_we[r];
            sel_addr  = req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[r*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      if (!pick_any) begin
         burst_cnt_d = '0;
      end else if (winner != owner_q) begin
         owner_d     = req_id_t'(winner);
         burst_cnt_d = CNT_W'(1);
      end else if (burst_cnt_q < CNT_W'(BURST_MAX)) begin
         burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end

      mem_en_d    = pick_any;
      mem_we_d    = pick_any & sel_we;
      mem_addr_d  = pick_any ? sel_addr  : mem_addr_q;
      mem_wdata_d = pick_any ? sel_wdata : mem_wdata_q;
      rd_v1_d     = pick_any & ~sel_we;
      tag1_d      = winner;
      rd_v2_d     = rd_v1_q;
      tag2_d      = tag1_q;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q     <= REQ_RX_WR;
         burst_cnt_q <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_v1_q     <= 1'b0;
         rd_v2_q     <= 1'b0;
         tag1_q      <= '0;
         tag2_q      <= '0;
      end else begin
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_v1_q     <= rd_v1_d;
         rd_v2_q     <= rd_v2_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Memory read data lands one cycle after mem_en, so it is forwarded, not re-registered.
   assign rsp_valid = rd_v2_q ? (NUM_REQ'(1) << tag2_q) : '0;
   assign rsp_data  = rd_v2_q ? mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] grants_q [NUM_REQ];
   logic [STAT_WIDTH-1:0] grants_d [NUM_REQ];
   logic [STAT_WIDTH-1:0] wait_q   [NUM_REQ];
   logic [STAT_WIDTH-1:0] wait_d   [NUM_REQ];
   logic [STAT_WIDTH-1:0] max_q    [NUM_REQ];
   logic [STAT_WIDTH-1:0] max_d    [NUM_REQ];

   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         grants_d[r] = grants_q[r];
         wait_d[r]   = '0;
         max_d[r]    = max_q[r];
         if (stat_clr) begin
            grants_d[r] = '0;
            max_d[r]    = '0;
         end else begin
            if (req_ready[r]) grants_d[r] = sat_inc(grants_q[r]);
            if (req_valid[r] && !req_ready[r]) begin
               wait_d[r] = sat_inc(wait_q[r]);
               if (wait_d[r] > max_q[r]) max_d[r] = wait_d[r];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            grants_q[r] <= '0;
            wait_q[r]   <= '0;
            max_q[r]    <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            grants_q[r] <= grants_d[r];
            wait_q[r]   <= wait_d[r];
            max_q[r]    <= max_d[r];
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_pack
      assign stat_grants[g*STAT_WIDTH +: STAT_WIDTH]   = grants_q[g];
      assign stat_max_wait[g*STAT_WIDTH +: STAT_WIDTH] = max_q[g];
   end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: hand tables, directed sequences
// and randomized traffic against a request-level reference model.
module tb_fb_port_arbiter;
   import fb_arb_pkg::*;

   localparam int AW = FB_ADDR_WIDTH;
   localparam int DW = FB_DATA_WIDTH;
   localparam int BM = FB_BURST_MAX;

   logic                 clk = 1'b0;
   logic                 tb_reset;
   logic [2:0]           req_valid, req_we, req_ready, rsp_valid;
   logic [3*AW-1:0]      req_addr;
   logic [3*DW-1:0]      req_wdata;
   logic [DW-1:0]        rsp_data, mem_wdata, mem_rdata;
   logic                 mem_en, mem_we;
   logic [AW-1:0]        mem_addr;
`ifdef FB_ARB_STATS_EN
   logic                 tb_clr;
   logic [3*STAT_WIDTH-1:0] stat_grants, stat_max_wait;
`endif

   logic [2:0]           tb_valid, tb_we;
   logic [AW-1:0]        tb_addr  [3];
   logic [DW-1:0]        tb_wdata [3];

   always #5 clk = ~clk;

   assign req_valid = tb_valid;
   assign req_we    = tb_we;
   assign req_addr  = {tb_addr[2], tb_addr[1], tb_addr[0]};
   assign req_wdata = {tb_wdata[2], tb_wdata[1], tb_wdata[0]};

   fb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
      .clk       (clk),
      .reset     (tb_reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef FB_ARB_STATS_EN
      ,
      .stat_clr      (tb_clr),
      .stat_grants   (stat_grants),
      .stat_max_wait (stat_max_wait)
`endif
   );

   // Frame-buffer stand-in: 64 words, registered read.
   logic [DW-1:0] fb_mem [64] = '{default: 24'h5A5A5A};
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) fb_mem[mem_addr[5:0]] <= mem_wdata;
         else        mem_rdata <= fb_mem[mem_addr[5:0]];
      end
   end

   typedef struct {
      int      due;
      int      id;
      fb_req_t rq;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic [2:0] valid;
      logic [2:0] exp_ready;
   } vec_t;

   exp_t          mem_q[$];
   exp_t          rsp_q[$];
   logic [DW-1:0] shadow [64];
   int            m_owner, m_burst, cyc;
   int            checks = 0;
   int            errors = 0;
   logic [2:0]    last_ready, last_rsp;
   logic          last_mem_en;
   int            wait_run [3];
   int            wait_max [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Grant rule: owner keeps the port while valid and under its burst limit,
   // otherwise scan owner+1, owner+2, owner.
   function automatic logic [2:0] model_pick(input logic [2:0] v);
      int c;
      if (v == 3'b000) return 3'b000;
      if (v[m_owner] && m_burst < BM) return 3'(1 << m_owner);
      for (int k = 1; k <= 3; k++) begin
         c = (m_owner + k) % 3;
         if (v[c]) return 3'(1 << c);
      end
      return 3'b000;
   endfunction

   task automatic tick();
      logic [2:0] g;
      exp_t       e;
      int         w;
      @(negedge clk);
      g = tb_reset ? 3'b000 : model_pick(tb_valid);
      check("req_ready", 32'(req_ready), 32'(g));
      last_ready  = req_ready;
      last_mem_en = mem_en;
      last_rsp    = rsp_valid;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         e = mem_q.pop_front();
         check("mem_en", 32'(mem_en), 32'd1);
         check("mem_we", 32'(mem_we), 32'(e.rq.we));
         check("mem_addr", 32'(mem_addr), 32'(e.rq.addr));
         if (e.rq.we) check("mem_wdata", 32'(mem_wdata), 32'(e.rq.wdata));
      end else begin
         check("mem_en_idle", 32'(mem_en), 32'd0);
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         e = rsp_q.pop_front();
         check("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
         check("rsp_data", 32'(rsp_data), 32'(e.data));
      end else begin
         check("rsp_idle", 32'(rsp_valid), 32'd0);
      end
      for (int r = 0; r < 3; r++) begin
         if (tb_valid[r] && !g[r]) wait_run[r]++;
         else                      wait_run[r] = 0;
         if (wait_run[r] > wait_max[r]) wait_max[r] = wait_run[r];
      end
      if (tb_reset) begin
         mem_q.delete();
         rsp_q.delete();
         m_owner = 0;
         m_burst = 0;
      end else if (g == 3'b000) begin
         m_burst = 0;
      end else begin
         w       = g[0] ? 0 : (g[1] ? 1 : 2);
         e.due   = cyc + 1;
         e.id    = w;
         e.rq    = '{we: tb_we[w], addr: tb_addr[w], wdata: tb_wdata[w]};
         e.data  = shadow[tb_addr[w][5:0]];
         mem_q.push_back(e);
         if (tb_we[w]) begin
            shadow[tb_addr[w][5:0]] = tb_wdata[w];
         end else begin
            e.due = cyc + 2;
            rsp_q.push_back(e);
         end
         if (w != m_owner) begin
            m_owner = w;
            m_burst = 1;
         end else if (m_burst < BM) begin
            m_burst++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic new_req(input int r, input bit allow_write);
      tb_we[r]    = allow_write ? 1'($urandom_range(0, 1)) : 1'b0;
      tb_addr[r]  = AW'($urandom_range(0, 63));
      tb_wdata[r] = DW'($urandom);
   endtask

   task automatic clear_waits();
      for (int r = 0; r < 3; r++) begin
         wait_run[r] = 0;
         wait_max[r] = 0;
      end
   endtask

   task automatic do_reset();
      tb_valid = 3'b000;
      tb_reset = 1'b1;
      tick();
      tb_reset = 1'b0;
      clear_waits();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
      check({tag, "_mem_en"},    32'(mem_en),    32'd0);
      check({tag, "_mem_we"},    32'(mem_we),    32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [10];
      int   grants, en_cnt, rsp_cnt;

      vecs[0] = '{3'b000, 3'b000};
      vecs[1] = '{3'b110, 3'b010};
      vecs[2] = '{3'b101, 3'b100};
      vecs[3] = '{3'b011, 3'b001};
      vecs[4] = '{3'b111, 3'b001};
      vecs[5] = '{3'b110, 3'b010};
      vecs[6] = '{3'b100, 3'b100};
      vecs[7] = '{3'b001, 3'b001};
      vecs[8] = '{3'b000, 3'b000};
      vecs[9] = '{3'b010, 3'b010};

      for (int i = 0; i < 64; i++) shadow[i] = 24'h5A5A5A;
      tb_reset = 1'b1;
      tb_valid = 3'b000;
      tb_we    = 3'b000;
`ifdef FB_ARB_STATS_EN
      tb_clr   = 1'b0;
`endif
      for (int r = 0; r < 3; r++) begin
         tb_addr[r]  = '0;
         tb_wdata[r] = '0;
      end
      cyc = 0;
      m_owner = 0;
      m_burst = 0;
      clear_waits();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      tb_reset = 1'b0;

      // Write then read back through a different requester.
      tb_valid = 3'b001; tb_we[0] = 1'b1; tb_addr[0] = 20'd5; tb_wdata[0] = 24'hA1B2C3;
      tick();
      tb_valid = 3'b010; tb_we[1] = 1'b0; tb_addr[1] = 20'd5;
      tick();
      tb_valid = 3'b000;
      tick();
      check("wr_rd_rsp_valid", 32'(rsp_valid), 32'h2);
      check("wr_rd_rsp_data",  32'(rsp_data),  32'hA1B2C3);
      tick();

      // Grant table from a freshly reset arbiter; all reads.
      do_reset();
      tb_we = 3'b000;
      for (int r = 0; r < 3; r++) tb_addr[r] = AW'(20 + r);
      for (int i = 0; i < 10; i++) begin
         tb_valid = vecs[i].valid;
         tick();
         check($sformatf("table_%0d", i), 32'(last_ready), 32'(vecs[i].exp_ready));
      end
      tb_valid = 3'b000;
      tick();
      tick();

      // Lone requester 2: grant every cycle, no bubbles.
      grants = 0;
      en_cnt = 0;
      tb_valid = 3'b100;
      new_req(2, 1'b1);
      for (int i = 0; i < 21; i++) begin
         if (i == 20) tb_valid = 3'b000;
         tick();
         if (last_ready[2]) begin
            grants++;
            new_req(2, 1'b1);
         end
         if (last_mem_en) en_cnt++;
      end
      check("solo_grants", 32'(grants), 32'd20);
      check("solo_mem_en", 32'(en_cnt), 32'd20);
      tick();

      // Alternating reads from requesters 1 and 2 to known contents.
      tb_valid = 3'b001; tb_we[0] = 1'b1; tb_addr[0] = 20'd10; tb_wdata[0] = 24'h10AA10;
      tick();
      tb_addr[0] = 20'd11; tb_wdata[0] = 24'h11BB11;
      tick();
      tb_we[1] = 1'b0; tb_addr[1] = 20'd10;
      tb_we[2] = 1'b0; tb_addr[2] = 20'd11;
      rsp_cnt = 0;
      for (int i = 0; i < 18; i++) begin
         tb_valid = (i >= 16) ? 3'b000 : ((i % 2 == 0) ? 3'b010 : 3'b100);
         tick();
         if (last_rsp != 3'b000) rsp_cnt++;
      end
      check("alt_rsp_count", 32'(rsp_cnt), 32'd16);

      // Reset the cycle after a read handshake: the response must vanish.
      tb_valid = 3'b010;
      tick();
      tb_valid = 3'b000;
      tb_reset = 1'b1;
      tick();
      tb_reset = 1'b0;
      check_reset_outputs("midrst");
      rsp_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (last_rsp != 3'b000) rsp_cnt++;
      end
      check("midrst_no_rsp", 32'(rsp_cnt), 32'd0);

      // Saturated contention: 8x0, 8x1, 8x2 repeating.
      do_reset();
      for (int r = 0; r < 3; r++) new_req(r, 1'b1);
      tb_valid = 3'b111;
      for (int i = 0; i < 48; i++) begin
         tick();
         check("burst_pattern", 32'(last_ready), 32'(1 << ((i / 8) % 3)));
         for (int r = 0; r < 3; r++) if (last_ready[r]) new_req(r, 1'b1);
      end
      for (int r = 0; r < 3; r++) check($sformatf("max_wait_%0d", r), 32'(wait_max[r]), 32'd16);
`ifdef FB_ARB_STATS_EN
      for (int r = 0; r < 3; r++) begin
         check($sformatf("stat_grants_%0d", r),   32'(stat_grants[r*16 +: 16]),   32'd16);
         check($sformatf("stat_max_wait_%0d", r), 32'(stat_max_wait[r*16 +: 16]), 32'd16);
      end
      tb_valid = 3'b000;
      tb_clr   = 1'b1;
      tick();
      tb_clr   = 1'b0;
      check("stat_clr_grants", 32'(stat_grants),   32'd0);
      check("stat_clr_wait",   32'(stat_max_wait), 32'd0);
`endif
      tb_valid = 3'b000;
      tick();
      tick();

      // Random traffic with withdrawals, checked cycle by cycle by the model.
      do_reset();
      last_ready = 3'b000;
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < 3; r++) begin
            if (tb_valid[r] && !last_ready[r]) begin
               if ($urandom_range(0, 7) == 0) tb_valid[r] = 1'b0;
            end else begin
               tb_valid[r] = ($urandom_range(0, 3) != 0);
               new_req(r, 1'b1);
            end
         end
         tick();
      end
      tb_valid = 3'b000;
      repeat (3) tick();
      check("drain_mem_q", 32'(mem_q.size()), 32'd0);
      check("drain_rsp_q", 32'(rsp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
